if_fetch_sequencer: RTL

- Fetch-stage sequencer directly upstream of the instruction stall mux.
- Owns the PC register and drives the synchronous instruction memory address, which has a 1-cycle read latency.
- Produces the `instruction_stall` and `past_instruction` pair consumed by the stall mux, plus the matching ID-stage PC, valid and flush indications.
- Handles the boot bubble, load-use stalls and taken-branch kills.

---
 rtl/if_fetch_sequencer.sv | 106 ++++++++++
 1 files changed

// File: rtl/if_fetch_sequencer.sv
// Fetch-stage sequencer: owns the PC, drives the 1-cycle-latency IM, and feeds the ID stall mux.
// Outputs are registered (Moore on state) except im_addr (PC register) and im_oe (follows reset).
module if_fetch_sequencer #(
  parameter int unsigned           DATA_SIZE = 32,
  parameter int unsigned           ADDR_SIZE = 32,
  parameter logic [ADDR_SIZE-1:0]  RESET_PC  = 32'h0000_0000,
  parameter logic [DATA_SIZE-1:0]  NOP_INST  = 32'h0000_0013
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_pc_stall,
  input  logic                 i_branch_taken,
  input  logic [ADDR_SIZE-1:0] i_branch_target,
  input  logic [DATA_SIZE-1:0] i_instruction,
  output logic [ADDR_SIZE-1:0] o_im_addr,
  output logic                 o_im_oe,
  output logic                 o_instruction_stall,
  output logic [DATA_SIZE-1:0] o_past_instruction,
  output logic [ADDR_SIZE-1:0] o_pc_id,
  output logic                 o_valid_id,
  output logic                 o_flush_id
);

  typedef enum logic [1:0] {
    ST_BOOT,
    ST_RUN,
    ST_HOLD,
    ST_KILL
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ADDR_SIZE-1:0] r_pc;
  logic [ADDR_SIZE-1:0] r_pc_id;
  logic [DATA_SIZE-1:0] r_past;
  logic [ADDR_SIZE-1:0] w_pc_nxt;
  logic                 w_valid;
  logic                 w_flush;
  logic                 w_istall;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Transitions are identical from every state; only the outputs differ.
  always_comb begin
    w_state_nxt = ST_RUN;
    w_valid     = 1'b0;
    w_flush     = 1'b0;
    w_istall    = 1'b0;
    case (r_state)
      ST_BOOT: w_valid = 1'b0;
      ST_RUN:  w_valid = 1'b1;
      ST_HOLD: begin
        w_valid  = 1'b1;
        w_istall = 1'b1;
      end
      ST_KILL: w_flush = 1'b1;
      default: w_valid = 1'b0;
    endcase
    if (i_branch_taken) begin
      w_state_nxt = ST_KILL;
    end else if (i_pc_stall) begin
      w_state_nxt = ST_HOLD;
    end
  end

  always_comb begin
    w_pc_nxt = r_pc + ADDR_SIZE'(4);
    if (i_branch_taken) begin
      w_pc_nxt = i_branch_target;
    end else if (i_pc_stall) begin
      w_pc_nxt = r_pc;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_pc    <= RESET_PC;
      r_pc_id <= RESET_PC;
      r_past  <= NOP_INST;
    end else begin
      r_pc <= w_pc_nxt;
      if (i_branch_taken || !i_pc_stall) begin
        r_pc_id <= r_pc;
      end
      // Tracks the stall-mux output so a held instruction survives the IM moving on.
      if (!w_istall) begin
        r_past <= i_branch_taken ? NOP_INST : i_instruction;
      end
    end
  end

  assign o_im_addr           = r_pc;
  assign o_im_oe             = i_rst;
  assign o_instruction_stall = w_istall;
  assign o_past_instruction  = r_past;
  assign o_pc_id             = r_pc_id;
  assign o_valid_id          = w_valid;
  assign o_flush_id          = w_flush;

endmodule
